// File: rtl/encrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_pkg
// Description : Shared constants, FSM state type and width-generic layer /
//               key-schedule helpers for the encrypt_v3 SPN cipher core.
//               Helpers work on maximum-width vectors and take the active
//               width as an argument, so one package serves every
//               parameterisation of the core.
// Revision    : 1.0 - initial release
// ============================================================================
package encrypt_pkg;

    // Upper bounds for the width-generic helpers.
    localparam int c_MAX_B = 128;
    localparam int c_MAX_K = 256;

    // Nibble tables, entry 0 in the most-significant nibble.
    localparam logic [63:0] c_SBOX  = 64'hC56B90AD3EF84712;
    localparam logic [63:0] c_ISBOX = 64'h5EF8C12DB463079A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYFWD = 3'd1,
        ROUND  = 3'd2,
        FINAL  = 3'd3,
        ACK    = 3'd4
    } state_t;

    function automatic logic [3:0] nib_lookup(input logic [63:0] tbl, input logic [3:0] v);
        int pos;
        pos = 60 - 4 * int'(v);
        return tbl[pos +: 4];
    endfunction

    function automatic logic [c_MAX_B-1:0] sbox_layer(input logic [c_MAX_B-1:0] x, input int nb);
        logic [c_MAX_B-1:0] y;
        y = x;
        for (int j = 0; j < c_MAX_B / 4; j++) begin
            if (j < nb / 4) y[4*j +: 4] = nib_lookup(c_SBOX, x[4*j +: 4]);
        end
        return y;
    endfunction

    function automatic logic [c_MAX_B-1:0] isbox_layer(input logic [c_MAX_B-1:0] x, input int nb);
        logic [c_MAX_B-1:0] y;
        y = x;
        for (int j = 0; j < c_MAX_B / 4; j++) begin
            if (j < nb / 4) y[4*j +: 4] = nib_lookup(c_ISBOX, x[4*j +: 4]);
        end
        return y;
    endfunction

    // Bit i -> (i*nb/4) mod (nb-1); the top bit stays in place (copied by y = x).
    function automatic logic [c_MAX_B-1:0] p_layer(input logic [c_MAX_B-1:0] x, input int nb);
        logic [c_MAX_B-1:0] y;
        int d;
        y = x;
        for (int i = 0; i < c_MAX_B; i++) begin
            if (i < nb - 1) begin
                d    = (i * (nb / 4)) % (nb - 1);
                y[d] = x[i];
            end
        end
        return y;
    endfunction

    function automatic logic [c_MAX_B-1:0] ip_layer(input logic [c_MAX_B-1:0] x, input int nb);
        logic [c_MAX_B-1:0] y;
        int d;
        y = x;
        for (int i = 0; i < c_MAX_B; i++) begin
            if (i < nb - 1) begin
                d    = (i * (nb / 4)) % (nb - 1);
                y[i] = x[d];
            end
        end
        return y;
    endfunction

    // rk_{r+1} = rotl(rk_r, 13) with bits [4:0] ^ r1, where r1 = (r+1) mod 32.
    function automatic logic [c_MAX_K-1:0] key_step(input logic [c_MAX_K-1:0] k, input int nk,
                                                    input logic [4:0] r1);
        logic [c_MAX_K-1:0] y;
        y = k;
        for (int i = 0; i < c_MAX_K; i++) begin
            if (i < nk) y[(i + 13) % nk] = k[i];
        end
        y[4:0] = y[4:0] ^ r1;
        return y;
    endfunction

    // rk_r = rotr(rk_{r+1} ^ r1, 13).
    function automatic logic [c_MAX_K-1:0] ikey_step(input logic [c_MAX_K-1:0] k, input int nk,
                                                     input logic [4:0] r1);
        logic [c_MAX_K-1:0] t;
        logic [c_MAX_K-1:0] y;
        t      = k;
        t[4:0] = t[4:0] ^ r1;
        y      = t;
        for (int i = 0; i < c_MAX_K; i++) begin
            if (i < nk) y[i] = t[(i + 13) % nk];
        end
        return y;
    endfunction

endpackage : encrypt_pkg
`default_nettype wire

// File: rtl/encrypt_v3_round.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_v3_round
// Description : Combinational single round plus one key-schedule step.
//               i_dir = 0 : x' = P(S(x ^ rk_r)), key -> rk_{r+1}, idx -> r+1
//               i_dir = 1 : key -> rk_r (i_idx holds r+1),
//                           x' = S^-1(P^-1(x)) ^ rk_r, idx -> r
// Ports       : i_dir  - direction (0 forward, 1 inverse)
//               i_x    - block in        o_x   - block out
//               i_key  - round key in    o_key - stepped key out
//               i_idx  - key index in    o_idx - key index out
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_v3_round
    import encrypt_pkg::*;
#(
    parameter int N_B = 64,
    parameter int N_K = 80,
    parameter int CW  = 6
) (
    input  logic           i_dir,
    input  logic [N_B-1:0] i_x,
    input  logic [N_K-1:0] i_key,
    input  logic [CW-1:0]  i_idx,
    output logic [N_B-1:0] o_x,
    output logic [N_K-1:0] o_key,
    output logic [CW-1:0]  o_idx
);

    logic [CW-1:0]  w_idx_inc;
    logic [CW-1:0]  w_idx_dec;
    logic [N_K-1:0] w_k_fwd;
    logic [N_K-1:0] w_k_inv;
    logic [N_B-1:0] w_x_enc;
    logic [N_B-1:0] w_x_dec;

    assign w_idx_inc = i_idx + CW'(1);
    assign w_idx_dec = i_idx - CW'(1);

    // The XOR constant is the index of the key being produced (fwd) or
    // the index of the key being consumed (inv); 5-bit cast gives mod 32.
    assign w_k_fwd = N_K'(key_step(c_MAX_K'(i_key), N_K, 5'(w_idx_inc)));
    assign w_k_inv = N_K'(ikey_step(c_MAX_K'(i_key), N_K, 5'(i_idx)));

    assign w_x_enc = N_B'(p_layer(sbox_layer(c_MAX_B'(i_x ^ i_key[N_B-1:0]), N_B), N_B));
    assign w_x_dec = N_B'(isbox_layer(ip_layer(c_MAX_B'(i_x), N_B), N_B)) ^ w_k_inv[N_B-1:0];

    assign o_x   = i_dir ? w_x_dec   : w_x_enc;
    assign o_key = i_dir ? w_k_inv   : w_k_fwd;
    assign o_idx = i_dir ? w_idx_dec : w_idx_inc;

endmodule : encrypt_v3_round
`default_nettype wire

// File: rtl/encrypt_v3.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_v3
// Description : Multi-cycle PRESENT-style SPN cipher, encrypt and decrypt,
//               U rounds per clock, 4-phase req/ack handshake.
// Ports       : clk  - clock (rising edge)
//               rst  - asynchronous reset, active low
//               req  - request (k, m, mode sampled when accepted in IDLE)
//               ack  - acknowledge, c valid while high
//               mode - 0 encrypt, 1 decrypt
//               k    - key [N_K]
//               m    - input block [N_B]
//               c    - output block [N_B], registered, held until next FINAL
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_v3
    import encrypt_pkg::*;
#(
    parameter int N_B = 64,
    parameter int N_K = 80,
    parameter int N_R = 32,
    parameter int U   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    output logic           ack,
    input  logic           mode,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic [N_B-1:0] c
);

    localparam int              c_CW = $clog2(N_R + 1);
    localparam logic [c_CW-1:0] c_NR = c_CW'(N_R);

    generate
        if (N_R % U != 0) begin : g_bad_unroll
            $error("encrypt_v3: N_R must be a multiple of U");
        end
        if ((N_B % 4 != 0) || (N_B < 8) || (N_B > c_MAX_B)) begin : g_bad_nb
            $error("encrypt_v3: N_B must be a multiple of 4 in 8..c_MAX_B");
        end
        if ((N_K < N_B) || (N_K > c_MAX_K)) begin : g_bad_nk
            $error("encrypt_v3: N_K must be in N_B..c_MAX_K");
        end
        if (N_R < 1) begin : g_bad_nr
            $error("encrypt_v3: N_R must be at least 1");
        end
    endgenerate

    state_t          r_fsm;
    state_t          w_fsm_nxt;
    logic            r_mode;
    logic [N_B-1:0]  r_blk;
    logic [N_B-1:0]  r_c;
    logic [N_K-1:0]  r_key;
    logic [c_CW-1:0] r_cnt;
    logic            w_ack;

    logic [N_B-1:0]  w_x [0:U];
    logic [N_K-1:0]  w_k [0:U];
    logic [c_CW-1:0] w_i [0:U];
    logic            w_dir;
    logic            w_whiten;
    logic            w_last;

    // KEYFWD reuses the forward key step of the chain, so the chain runs
    // inverse only while decrypting in ROUND.
    assign w_dir    = (r_fsm == ROUND) && r_mode;
    // Decrypt input whitening with rk_{N_R} happens on the first ROUND cycle,
    // the only time the counter sits at N_R inside ROUND.
    assign w_whiten = w_dir && (r_cnt == c_NR);

    assign w_x[0] = w_whiten ? (r_blk ^ r_key[N_B-1:0]) : r_blk;
    assign w_k[0] = r_key;
    assign w_i[0] = r_cnt;

    generate
        for (genvar g = 0; g < U; g++) begin : g_round
            encrypt_v3_round #(
                .N_B (N_B),
                .N_K (N_K),
                .CW  (c_CW)
            ) u_round (
                .i_dir (w_dir),
                .i_x   (w_x[g]),
                .i_key (w_k[g]),
                .i_idx (w_i[g]),
                .o_x   (w_x[g+1]),
                .o_key (w_k[g+1]),
                .o_idx (w_i[g+1])
            );
        end
    endgenerate

    // Last step of a phase: counter lands on N_R going up, on 0 going down.
    assign w_last = w_dir ? (w_i[U] == '0) : (w_i[U] == c_NR);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_fsm_nxt;
    end

    // Next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (req) w_fsm_nxt = mode ? KEYFWD : ROUND;
            KEYFWD:  if (w_last) w_fsm_nxt = ROUND;
            ROUND:   if (w_last) w_fsm_nxt = FINAL;
            FINAL:   w_fsm_nxt = ACK;
            ACK:     if (!req) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_ack = 1'b0;
        if (r_fsm == ACK) w_ack = 1'b1;
    end

    assign ack = w_ack;
    assign c   = r_c;

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
            r_blk  <= '0;
            r_key  <= '0;
            r_cnt  <= '0;
            r_c    <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (req) begin
                        r_mode <= mode;
                        r_blk  <= m;
                        r_key  <= k;
                        r_cnt  <= '0;
                    end
                end
                KEYFWD: begin
                    r_key <= w_k[U];
                    r_cnt <= w_i[U];
                end
                ROUND: begin
                    r_blk <= w_x[U];
                    r_key <= w_k[U];
                    r_cnt <= w_i[U];
                end
                FINAL: begin
                    r_c <= r_mode ? r_blk : (r_blk ^ r_key[N_B-1:0]);
                end
                default: ;
            endcase
        end
    end

endmodule : encrypt_v3
`default_nettype wire

// File: tb/tb_encrypt_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_v3
// Description : Self-checking bench for encrypt_v3. Three instances run in
//               lock-step on shared handshake inputs: 64/80/32/U=1,
//               64/80/32/U=4 and 16/32/8/U=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encrypt_v3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        mode;
    logic [79:0] k;
    logic [63:0] m_a, m_b;
    logic [15:0] m_s;
    logic        ack_a, ack_b, ack_s;
    logic [63:0] c_a, c_b;
    logic [15:0] c_s;

    always #5 clk = ~clk;

    encrypt_v3 #(.N_B(64), .N_K(80), .N_R(32), .U(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .ack(ack_a), .mode(mode), .k(k), .m(m_a), .c(c_a));
    encrypt_v3 #(.N_B(64), .N_K(80), .N_R(32), .U(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .ack(ack_b), .mode(mode), .k(k), .m(m_b), .c(c_b));
    encrypt_v3 #(.N_B(16), .N_K(32), .N_R(8), .U(2)) dut_s (
        .clk(clk), .rst(rst), .req(req), .ack(ack_s), .mode(mode), .k(k[31:0]), .m(m_s), .c(c_s));

    int n_pass  = 0;
    int n_total = 0;
    int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int isb[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] sub(input logic [127:0] x, input int nb, input bit inv);
        logic [127:0] y;
        int v;
        y = x;
        for (int j = 0; j < nb / 4; j++) begin
            v = int'(x[4*j +: 4]);
            y[4*j +: 4] = inv ? 4'(isb[v]) : 4'(sb[v]);
        end
        return y;
    endfunction

    function automatic logic [127:0] perm(input logic [127:0] x, input int nb, input bit inv);
        logic [127:0] y;
        int d;
        y = '0;
        for (int i = 0; i < nb; i++) begin
            d = (i == nb - 1) ? i : (i * (nb / 4)) % (nb - 1);
            if (!inv) y[d] = x[i];
            else      y[i] = x[d];
        end
        return y;
    endfunction

    function automatic logic [127:0] ref_cipher(input int nb, input int nk, input int nr,
                                                input bit dec, input logic [255:0] key,
                                                input logic [127:0] blk);
        logic [255:0] rk [0:32];
        logic [255:0] km;
        logic [127:0] bm;
        logic [127:0] x;
        km    = (256'd1 << nk) - 256'd1;
        bm    = (128'd1 << nb) - 128'd1;
        rk[0] = key & km;
        for (int r = 0; r < nr; r++)
            rk[r+1] = (((rk[r] << 13) | (rk[r] >> (nk - 13))) & km) ^ 256'((r + 1) % 32);
        if (!dec) begin
            x = blk & bm;
            for (int r = 0; r < nr; r++)
                x = perm(sub(x ^ (rk[r][127:0] & bm), nb, 1'b0), nb, 1'b0);
            x = x ^ (rk[nr][127:0] & bm);
        end else begin
            x = (blk ^ rk[nr][127:0]) & bm;
            for (int r = nr - 1; r >= 0; r--)
                x = (sub(perm(x, nb, 1'b1), nb, 1'b1) ^ rk[r][127:0]) & bm;
        end
        return x;
    endfunction

    function automatic logic [63:0] ref64(input bit dec, input logic [79:0] kk, input logic [63:0] mm);
        return 64'(ref_cipher(64, 80, 32, dec, 256'(kk), 128'(mm)));
    endfunction

    function automatic logic [15:0] ref16(input bit dec, input logic [79:0] kk, input logic [15:0] mm);
        return 16'(ref_cipher(16, 32, 8, dec, 256'(kk[31:0]), 128'(mm)));
    endfunction

    // ---------------- transaction ----------------
    // Latencies count rising edges after the sampling edge; -1 means no ack.
    task automatic run(input bit md, input logic [79:0] kk, input logic [63:0] ma,
                       input logic [63:0] mb, input logic [15:0] ms,
                       output int la, output int lb, output int ls);
        @(posedge clk); #1;
        mode = md; k = kk; m_a = ma; m_b = mb; m_s = ms; req = 1'b1;
        @(posedge clk); #1;
        // inputs are don't-care after acceptance
        mode = ~md;
        k    = 80'({$urandom(), $urandom(), $urandom()});
        m_a  = {$urandom(), $urandom()};
        m_b  = {$urandom(), $urandom()};
        m_s  = 16'($urandom());
        la = -1; lb = -1; ls = -1;
        for (int n = 1; n <= 200 && (la < 0 || lb < 0 || ls < 0); n++) begin
            @(posedge clk); #1;
            if (ack_a && la < 0) la = n;
            if (ack_b && lb < 0) lb = n;
            if (ack_s && ls < 0) ls = n;
        end
        check("ack_hold", 128'({ack_a, ack_b, ack_s}), 128'(3'b111));
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_fall", 128'({ack_a, ack_b, ack_s}), 128'(3'b000));
    endtask

    typedef struct {
        bit          md;
        logic [79:0] kk;
        logic [63:0] mm;
        logic [63:0] exp64;
        logic [15:0] exp16;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int la, lb, ls;
        int hi_a, hi_b, hi_s;
        logic [79:0] kk;
        logic [63:0] ma, ca, cb;
        logic [15:0] cs;

        for (int i = 0; i < 16; i++) isb[sb[i]] = i;

        rst = 1'b0; req = 1'b0; mode = 1'b0; k = '0; m_a = '0; m_b = '0; m_s = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ack", 128'({ack_a, ack_b, ack_s}), 128'(3'b000));
        check("rst c_a", 128'(c_a), 128'(0));
        check("rst c_b", 128'(c_b), 128'(0));
        check("rst c_s", 128'(c_s), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle ack", 128'({ack_a, ack_b, ack_s}), 128'(3'b000));

        // ---------- table-driven vectors ----------
        tbl[0] = '{1'b0, 80'h0, 64'h0, 64'h0, 16'h0};
        tbl[1] = '{1'b0, {80{1'b1}}, {64{1'b1}}, 64'h0, 16'h0};
        tbl[2] = '{1'b0, 80'h0123456789abcdef0123, 64'hfedcba9876543210, 64'h0, 16'h0};
        tbl[3] = '{1'b1, 80'h0, 64'h0, 64'h0, 16'h0};
        tbl[4] = '{1'b1, 80'h1, 64'h8000000000000001, 64'h0, 16'h0};
        tbl[5] = '{1'b1, 80'hdeadbeefcafef00d1234, 64'h0011223344556677, 64'h0, 16'h0};
        for (int i = 0; i < 6; i++) begin
            tbl[i].exp64 = ref64(tbl[i].md, tbl[i].kk, tbl[i].mm);
            tbl[i].exp16 = ref16(tbl[i].md, tbl[i].kk, tbl[i].mm[15:0]);
        end
        for (int i = 0; i < 6; i++) begin
            run(tbl[i].md, tbl[i].kk, tbl[i].mm, tbl[i].mm, tbl[i].mm[15:0], la, lb, ls);
            check($sformatf("tbl%0d c_a", i), 128'(c_a), 128'(tbl[i].exp64));
            check($sformatf("tbl%0d c_b", i), 128'(c_b), 128'(tbl[i].exp64));
            check($sformatf("tbl%0d c_s", i), 128'(c_s), 128'(tbl[i].exp16));
            check_int($sformatf("tbl%0d lat_a", i), la, tbl[i].md ? 65 : 33);
            check_int($sformatf("tbl%0d lat_b", i), lb, tbl[i].md ? 17 : 9);
            check_int($sformatf("tbl%0d lat_s", i), ls, tbl[i].md ? 9 : 5);
        end

        // ---------- early req drop: ack must be a one-cycle pulse ----------
        kk = 80'h5555aaaa5555aaaa5555;
        ma = 64'h0f0f0f0f12345678;
        @(posedge clk); #1;
        mode = 1'b0; k = kk; m_a = ma; m_b = ma; m_s = ma[15:0]; req = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0;
        hi_a = 0; hi_b = 0; hi_s = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ack_a) hi_a++;
            if (ack_b) hi_b++;
            if (ack_s) hi_s++;
        end
        check_int("drop pulse_a", hi_a, 1);
        check_int("drop pulse_b", hi_b, 1);
        check_int("drop pulse_s", hi_s, 1);
        check("drop c_a", 128'(c_a), 128'(ref64(1'b0, kk, ma)));
        check("drop c_b", 128'(c_b), 128'(ref64(1'b0, kk, ma)));
        check("drop c_s", 128'(c_s), 128'(ref16(1'b0, kk, ma[15:0])));
        run(1'b1, kk, ma, ma, ma[15:0], la, lb, ls);
        check("post-drop c_a", 128'(c_a), 128'(ref64(1'b1, kk, ma)));
        check_int("post-drop lat_a", la, 65);

        // ---------- reset in the middle of ROUND ----------
        kk = 80'({$urandom(), $urandom(), $urandom()});
        ma = {$urandom(), $urandom()};
        @(posedge clk); #1;
        mode = 1'b0; k = kk; m_a = ma; m_b = ma; m_s = ma[15:0]; req = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst ack", 128'({ack_a, ack_b, ack_s}), 128'(3'b000));
        check("midrst c_a", 128'(c_a), 128'(0));
        check("midrst c_b", 128'(c_b), 128'(0));
        check("midrst c_s", 128'(c_s), 128'(0));
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        run(1'b0, 80'h0, 64'h0, 64'h0, 16'h0, la, lb, ls);
        check("golden c_a", 128'(c_a), 128'(ref64(1'b0, 80'h0, 64'h0)));
        check("golden c_b", 128'(c_b), 128'(ref64(1'b0, 80'h0, 64'h0)));
        check("golden c_s", 128'(c_s), 128'(ref16(1'b0, 80'h0, 16'h0)));
        check_int("golden lat_a", la, 33);

        // ---------- random round trips ----------
        for (int t = 0; t < 100; t++) begin
            kk = 80'({$urandom(), $urandom(), $urandom()});
            ma = {$urandom(), $urandom()};
            run(1'b0, kk, ma, ma, ma[15:0], la, lb, ls);
            ca = c_a; cb = c_b; cs = c_s;
            check($sformatf("rnd%0d enc_a", t), 128'(ca), 128'(ref64(1'b0, kk, ma)));
            check($sformatf("rnd%0d enc_b", t), 128'(cb), 128'(ref64(1'b0, kk, ma)));
            check($sformatf("rnd%0d enc_s", t), 128'(cs), 128'(ref16(1'b0, kk, ma[15:0])));
            run(1'b1, kk, ca, cb, cs, la, lb, ls);
            check($sformatf("rnd%0d dec_a", t), 128'(c_a), 128'(ma));
            check($sformatf("rnd%0d dec_b", t), 128'(c_b), 128'(ma));
            check($sformatf("rnd%0d dec_s", t), 128'(c_s), 128'(ma[15:0]));
            if (t < 3) check_int($sformatf("rnd%0d dec lat_a", t), la, 65);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_encrypt_v3
`default_nettype wire

// File: doc/encrypt_v3.md
# encrypt_v3

Parametrised successor to the v2 multi-cycle block cipher core. It takes a key `k`, a block `m` and a direction `mode`, runs a PRESENT-style substitution–permutation network (SPN) over `N_R` rounds, and returns the result on `c`. The result is exchanged over a 4-phase `req`/`ack` handshake. Width, key size, round count and rounds-per-cycle (unroll factor) are parameters, and the block adds decryption. It sits behind the same request/acknowledge interface as earlier encrypt cores and drops into the existing vector-driven benches.

## Interface
- `N_B`, 64: block width in bits; multiple of 4, ≥ 8.
- `N_K`, 80: key width in bits; ≥ `N_B`.
- `N_R`, 32: number of rounds; ≥ 1.
- `U`, 1: rounds per clock; `N_R % U == 0` (elaboration error otherwise).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: request; 4-phase handshake.
- `ack` out 1: acknowledge; `c` is valid while high.
- `mode` in 1: 0 = encrypt, 1 = decrypt; sampled with `req`.
- `k` in `N_K`: cipher key; sampled with `req`.
- `m` in `N_B`: input block (plaintext, or ciphertext when decrypting); sampled with `req`.
- `c` out `N_B`: output block; registered.

## Operation
- Round keys:
  - `rk_0 = k`.
  - `rk_{r+1} = rotl(rk_r, 13)`, with bits [4:0] XOR `(r+1)` mod 32.
  - The round key is the low `N_B` bits of `rk_r`.
  - Inverse: `rk_r = rotr(rk_{r+1} ^ (r+1), 13)`.
- S-box: 4-bit, nibble-wise, `C56B90AD3EF84712` (index 0..F); the inverse table lives in the package.
- P-layer: bit i moves to `(i*N_B/4) mod (N_B-1)` for i < `N_B-1`; bit `N_B-1` is fixed.
- Encrypt: `x = m`; for r = 0..`N_R-1`, `x = P(S(x ^ rk_r))`; then `c = x ^ rk_{N_R}`.
- Decrypt: the key register first steps forward `N_R` times to reach `rk_{N_R}`. Then `x = m ^ rk_{N_R}`; for r = `N_R-1`..0, `x = S⁻¹(P⁻¹(x)) ^ rk_r`; then `c = x`.
- FSM states:
  - IDLE: on `req` = 1, capture `k`, `m` and `mode`. Go to KEYFWD if `mode` = 1, else ROUND.
  - KEYFWD: advance the key `U` steps per cycle for `N_R/U` cycles; the state register is untouched. Then go to ROUND.
  - ROUND: apply `U` rounds per cycle for `N_R/U` cycles, using the forward or inverse round chain. Then go to FINAL.
  - FINAL: apply whitening if encrypting, load `c`, set `ack` = 1. Go to ACK.
  - ACK: hold `ack` = 1 while `req` = 1. When `req` = 0, clear `ack` and go to IDLE.
- Round counter is `$clog2(N_R+1)` bits and counts up or down with direction; no wrap is reachable.
- `c` holds its last result until the next FINAL; it is never cleared by the handshake.

## Timing
- Reset (async, takes effect immediately): state = IDLE, `ack` = 0, `c` = 0, counter = 0, internal key/state registers = 0.
- Encrypt latency: `ack` rises `N_R/U + 1` rising edges after the edge that sampled `req` = 1.
- Decrypt latency: `2*N_R/U + 1` edges.
- After `req` falls, `ack` falls on the next edge; `req` is accepted again the following cycle in IDLE.
- `k`, `m` and `mode` may change freely after the sampling edge; they are ignored until the next IDLE acceptance.
- `req` dropped before `ack` (protocol violation): the operation still completes. FINAL sets `ack`, ACK sees `req` = 0 and clears `ack` one cycle later (1-cycle pulse), and `c` is valid.
- `req` still high when ACK exits: not possible, since ACK only exits on `req` = 0. A new request needs `req` to be low then high again.
- Reset asserted mid-KEYFWD/ROUND/ACK: the transaction is aborted with no partial `c`. The first request after release starts a fresh transaction.

## Structure
- Package `encrypt_pkg`:
  - S-box and inverse-S-box constants.
  - `sbox_layer`, `isbox_layer`, `p_layer`, `ip_layer` functions, width-generic on `N_B`.
  - Key-step and inverse key-step functions.
  - FSM state enum: IDLE, KEYFWD, ROUND, FINAL, ACK.
- Sub-module `encrypt_v3_round`: combinational; one round in either direction plus one key step.
  - Instantiated `U` times in a generate chain.
  - The top level holds the FSM, the counter and the registers.

## Test plan
- Golden vectors at `N_B` = 64, `N_K` = 80, `N_R` = 32, `U` = 1: `k` = 0, `m` = 0, `mode` = 0 → `c` equals the Python model value, with `ack` on edge 33. All `vectors_*.txt` entries must pass.
- Round-trip: encrypt then decrypt 100 random (`k`, `m`) pairs → decrypted `c` == `m`. Decrypt `ack` arrives on edge 65.
- Unroll: `U` = 4, same vectors → identical `c`; encrypt latency 9 edges, decrypt latency 17 edges.
- Reset mid-ROUND (round 10): `ack` = 0 and `c` = 0 immediately, before the next edge. After release, `k` = 0, `m` = 0 encrypt → the correct golden `c`.
- Early `req` drop two cycles after acceptance → `ack` is a 1-cycle pulse, `c` is correct, and the next request is accepted normally.
- Parameter sweep: `N_B` = 16, `N_K` = 32, `N_R` = 8, `U` = 2 → matches the model on 50 random vectors in both directions.
